// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM encoding
// and the datapath width check used at elaboration.
package writeback_unit_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

    // Byte/half extraction below is written for a 32-bit word only.
    function automatic bit data_width_ok(input int width);
        return width == WORD_WIDTH;
    endfunction

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load data formatter: selects the byte/half addressed by
// addr_lo from an aligned word and sign- or zero-extends it.
module load_formatter
    import writeback_unit_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    output logic [WORD_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        byte_sel = rdata[7:0];
        half_sel = rdata[15:0];
        data     = rdata;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // Misaligned halves are trapped upstream, so only addr_lo[1] matters.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage before the integer register file: retires one
// instruction at a time, waits for load data, and drives the RF write port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,

    input  logic                  lsu_rvalid,
    output logic                  lsu_rready,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit,

    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] busy_rd
);

    if (!data_width_ok(DATA_WIDTH)) begin : g_width_check
        $error("writeback_unit: DATA_WIDTH must be 32");
    end

    wb_state_t             state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rd_wen_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic [DATA_WIDTH-1:0] load_data;

    load_formatter u_load_formatter (
        .rdata   (lsu_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .data    (load_data)
    );

    // Handshake and hazard outputs decode registered state only, so no input
    // reaches them combinationally.
    assign in_ready   = (state == ST_IDLE);
    assign lsu_rready = (state == ST_WAIT_MEM);
    assign busy       = (state != ST_IDLE);
    assign busy_rd    = (busy && rd_wen_q) ? rd_q : '0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            commit    <= 1'b0;
        end else begin
            // Write strobes are single-cycle unless the WRITE entry below raises them.
            rf_wen <= 1'b0;
            commit <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        rd_q      <= in_rd;
                        rd_wen_q  <= in_rd_wen;
                        funct3_q  <= in_funct3;
                        addr_lo_q <= in_addr_lo;
                        if (in_is_load) begin
                            state <= ST_WAIT_MEM;
                        end else begin
                            state    <= ST_WRITE;
                            rf_wen   <= in_rd_wen && (in_rd != '0);
                            rf_waddr <= in_rd;
                            rf_wdata <= in_result;
                            commit   <= 1'b1;
                        end
                    end
                end

                ST_WAIT_MEM: begin
                    if (lsu_rvalid) begin
                        state    <= ST_WRITE;
                        rf_wen   <= rd_wen_q && (rd_q != '0);
                        rf_waddr <= rd_q;
                        rf_wdata <= load_data;
                        commit   <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
